// File: rtl/uart_bcd_reporter.sv
// Streams a snapshot of NUM_CH packed BCD words to a UART transmitter as ASCII,
// with separators, optional CR/LF, optional leading-zero blanking and bad-digit flagging.
module uart_bcd_reporter #(
    parameter int          NUM_CH   = 2,
    parameter int          DIGITS   = 4,
    parameter int          TERM_EN  = 1,
    parameter logic [7:0]  SEP_CHAR = 8'h2C,
    parameter int          GUARD    = 2
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst_n,
    input  logic                       start_send,
    input  logic [NUM_CH*DIGITS*4-1:0] data_in,
    input  logic                       blank_lz,
    input  logic                       tx_rdy,
    output logic                       tx_en,
    output logic [7:0]                 data_out,
    output logic                       busy,
    output logic                       end_send,
    output logic                       bad_digit
);
    localparam int W    = NUM_CH * DIGITS * 4;
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int DG_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int GC_W = (GUARD > 1) ? $clog2(GUARD) : 1;
    localparam logic [CH_W-1:0] LAST_CH    = CH_W'(NUM_CH - 1);
    localparam logic [DG_W-1:0] TOP_DG     = DG_W'(DIGITS - 1);
    localparam logic [GC_W-1:0] GUARD_LAST = GC_W'(GUARD - 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_LOAD, ST_SEND, ST_GUARD, ST_WAIT, ST_DONE
    } state_t;

    typedef enum logic [1:0] {PH_DIG, PH_SEP, PH_CR, PH_LF} phase_t;

    state_t            state_r;
    phase_t            phase_r;
    logic [W-1:0]      shadow_r;
    logic              blank_r;
    logic              lz_r;
    logic              last_r;
    logic [CH_W-1:0]   ch_r;
    logic [DG_W-1:0]   dg_r;
    logic [GC_W-1:0]   guard_r;
    logic [7:0]        byte_r;
    int                sh_s;
    logic [3:0]        nib_s;
    logic              skip_s;

    function automatic logic digit_bad(input logic [3:0] nib);
        return (nib > 4'd9);
    endfunction

    function automatic logic [7:0] digit_ascii(input logic [3:0] nib);
        if (digit_bad(nib)) begin
            return 8'h3F;
        end else begin
            return {4'h3, nib};
        end
    endfunction

    // Current nibble and whether it is a blankable leading zero (LS digit never skipped)
    always_comb begin
        sh_s   = (int'(ch_r) * DIGITS + int'(dg_r)) * 4;
        nib_s  = 4'(shadow_r >> sh_s);
        skip_s = blank_r && lz_r && (nib_s == 4'd0) && (dg_r != DG_W'(0));
    end

    // Record sequencer: byte selection, handshake, guard window and completion
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_r   <= ST_IDLE;
            phase_r   <= PH_DIG;
            shadow_r  <= {W{1'b0}};
            blank_r   <= 1'b0;
            lz_r      <= 1'b0;
            last_r    <= 1'b0;
            ch_r      <= CH_W'(0);
            dg_r      <= DG_W'(0);
            guard_r   <= GC_W'(0);
            byte_r    <= 8'h00;
            tx_en     <= 1'b0;
            data_out  <= 8'h00;
            busy      <= 1'b0;
            end_send  <= 1'b0;
            bad_digit <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    end_send <= 1'b0;
                    if (start_send) begin
                        shadow_r  <= data_in;
                        blank_r   <= blank_lz;
                        bad_digit <= 1'b0;
                        busy      <= 1'b1;
                        ch_r      <= CH_W'(0);
                        dg_r      <= TOP_DG;
                        phase_r   <= PH_DIG;
                        lz_r      <= 1'b1;
                        last_r    <= 1'b0;
                        state_r   <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    case (phase_r)
                        PH_DIG: begin
                            if (skip_s) begin
                                dg_r <= dg_r - DG_W'(1);
                            end else begin
                                byte_r <= digit_ascii(nib_s);
                                if (digit_bad(nib_s)) begin
                                    bad_digit <= 1'b1;
                                end
                                lz_r    <= 1'b0;
                                state_r <= ST_SEND;
                                if (dg_r != DG_W'(0)) begin
                                    dg_r <= dg_r - DG_W'(1);
                                end else if (ch_r != LAST_CH) begin
                                    phase_r <= PH_SEP;
                                end else if (TERM_EN != 0) begin
                                    phase_r <= PH_CR;
                                end else begin
                                    last_r <= 1'b1;
                                end
                            end
                        end
                        PH_SEP: begin
                            byte_r  <= SEP_CHAR;
                            ch_r    <= ch_r + CH_W'(1);
                            dg_r    <= TOP_DG;
                            lz_r    <= 1'b1;
                            phase_r <= PH_DIG;
                            state_r <= ST_SEND;
                        end
                        PH_CR: begin
                            byte_r  <= 8'h0D;
                            phase_r <= PH_LF;
                            state_r <= ST_SEND;
                        end
                        PH_LF: begin
                            byte_r  <= 8'h0A;
                            last_r  <= 1'b1;
                            state_r <= ST_SEND;
                        end
                        default: begin
                            busy    <= 1'b0;
                            state_r <= ST_IDLE;
                        end
                    endcase
                end
                ST_SEND: begin
                    if (tx_rdy) begin
                        data_out <= byte_r;
                        tx_en    <= 1'b1;
                        guard_r  <= GC_W'(0);
                        state_r  <= ST_GUARD;
                    end
                end
                ST_GUARD: begin
                    // tx_rdy may still show the previous idle level here
                    tx_en <= 1'b0;
                    if (guard_r == GUARD_LAST) begin
                        state_r <= ST_WAIT;
                    end else begin
                        guard_r <= guard_r + GC_W'(1);
                    end
                end
                ST_WAIT: begin
                    if (tx_rdy) begin
                        if (last_r) begin
                            end_send <= 1'b1;
                            state_r  <= ST_DONE;
                        end else begin
                            state_r  <= ST_LOAD;
                        end
                    end
                end
                ST_DONE: begin
                    end_send <= 1'b0;
                    busy     <= 1'b0;
                    state_r  <= ST_IDLE;
                end
                default: begin
                    tx_en    <= 1'b0;
                    end_send <= 1'b0;
                    busy     <= 1'b0;
                    state_r  <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_bcd_reporter.sv
// Directed bench for uart_bcd_reporter with a transmitter model busy 10 cycles per byte.
module tb_uart_bcd_reporter;
    logic        sys_clk    = 1'b0;
    logic        sys_rst_n  = 1'b0;
    logic        start_send = 1'b0;
    logic [31:0] data_in    = 32'h0;
    logic        blank_lz   = 1'b0;
    logic        tx_rdy     = 1'b1;
    logic        tx_en;
    logic [7:0]  data_out;
    logic        busy;
    logic        end_send;
    logic        bad_digit;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0] log_mem [0:1023];
    int         log_n      = 0;
    int         end_n      = 0;
    int         tx_cnt     = 0;
    int         end_tx_cnt = 0;
    bit         hold_low   = 1'b0;
    logic       bad_at_end = 1'b0;

    localparam logic [127:0] EXP_BASIC = 128'h3031_3233_2C36_3030_300D_0A;
    localparam logic [127:0] EXP_BLANK = 128'h3132_332C_3630_3030_0D0A;
    localparam logic [127:0] EXP_ZERO  = 128'h302C_300D_0A;
    localparam logic [127:0] EXP_BAD   = 128'h303F_3035_2C30_3030_370D_0A;
    localparam logic [127:0] EXP_VALID = 128'h3938_3736_2C34_3530_0D0A;

    uart_bcd_reporter #(
        .NUM_CH(2), .DIGITS(4), .TERM_EN(1), .SEP_CHAR(8'h2C), .GUARD(2)
    ) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start_send(start_send),
        .data_in(data_in), .blank_lz(blank_lz), .tx_rdy(tx_rdy),
        .tx_en(tx_en), .data_out(data_out), .busy(busy),
        .end_send(end_send), .bad_digit(bad_digit)
    );

    always #5 sys_clk = ~sys_clk;

    // Transmitter model and byte/end logger
    always @(negedge sys_clk) begin
        if (end_send) begin
            end_n      = end_n + 1;
            bad_at_end = bad_digit;
            end_tx_cnt = tx_cnt;
        end
        if (tx_en) begin
            if (log_n < 1024) log_mem[log_n] = data_out;
            log_n  = log_n + 1;
            tx_cnt = 10;
        end else if (tx_cnt > 0) begin
            tx_cnt = tx_cnt - 1;
        end
        tx_rdy = (tx_cnt == 0) && !hold_low;
    end

    task automatic tick();
        @(negedge sys_clk);
        #1;
    endtask

    task automatic start_record(input logic [31:0] d, input logic bl);
        data_in    = d;
        blank_lz   = bl;
        start_send = 1'b1;
        tick();
        start_send = 1'b0;
    endtask

    task automatic wait_end(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (end_send) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_bytes(input int base, input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (log_n - base >= n) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic collect(input int base, output int nb, output logic [127:0] st);
        st = 128'h0;
        nb = log_n - base;
        for (int i = base; i < log_n; i++) st = {st[119:0], log_mem[i]};
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        repeat (3) tick();
        tests_run += 5;
        if (tx_en !== 1'b0)     begin tests_failed++; $display("FAIL reset_tx_en: got %b expected 0", tx_en); end
        if (data_out !== 8'h00) begin tests_failed++; $display("FAIL reset_data_out: got %h expected 00", data_out); end
        if (busy !== 1'b0)      begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy); end
        if (end_send !== 1'b0)  begin tests_failed++; $display("FAIL reset_end_send: got %b expected 0", end_send); end
        if (bad_digit !== 1'b0) begin tests_failed++; $display("FAIL reset_bad_digit: got %b expected 0", bad_digit); end
        sys_rst_n = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_basic();
        int base, e0, nb;
        logic [127:0] st;
        bit ok;
        base = log_n;
        e0   = end_n;
        start_record(32'h6000_0123, 1'b0);
        tests_run++;
        if (busy !== 1'b1) begin tests_failed++; $display("FAIL basic_busy_start: got %b expected 1", busy); end
        wait_end(ok);
        tests_run += 3;
        if (ok !== 1'b1)        begin tests_failed++; $display("FAIL basic_timeout: got %b expected 1", ok); end
        if (busy !== 1'b1)      begin tests_failed++; $display("FAIL basic_busy_done: got %b expected 1", busy); end
        if (bad_digit !== 1'b0) begin tests_failed++; $display("FAIL basic_bad_digit: got %b expected 0", bad_digit); end
        repeat (3) tick();
        collect(base, nb, st);
        tests_run += 5;
        if (busy !== 1'b0)      begin tests_failed++; $display("FAIL basic_busy_after: got %b expected 0", busy); end
        if (nb !== 11)          begin tests_failed++; $display("FAIL basic_count: got %0d expected 11", nb); end
        if (st !== EXP_BASIC)   begin tests_failed++; $display("FAIL basic_stream: got %h expected %h", st, EXP_BASIC); end
        if (end_n - e0 !== 1)   begin tests_failed++; $display("FAIL basic_end_count: got %0d expected 1", end_n - e0); end
        if (end_tx_cnt !== 0)   begin tests_failed++; $display("FAIL basic_end_early: got %0d expected 0", end_tx_cnt); end
    endtask

    task automatic test_blanking();
        int base, nb;
        logic [127:0] st;
        bit ok;
        base = log_n;
        start_record(32'h6000_0123, 1'b1);
        wait_end(ok);
        repeat (3) tick();
        collect(base, nb, st);
        tests_run += 2;
        if (nb !== 10)        begin tests_failed++; $display("FAIL blank_count: got %0d expected 10", nb); end
        if (st !== EXP_BLANK) begin tests_failed++; $display("FAIL blank_stream: got %h expected %h", st, EXP_BLANK); end
        base = log_n;
        start_record(32'h0000_0000, 1'b1);
        wait_end(ok);
        repeat (3) tick();
        collect(base, nb, st);
        tests_run += 2;
        if (nb !== 5)         begin tests_failed++; $display("FAIL zero_count: got %0d expected 5", nb); end
        if (st !== EXP_ZERO)  begin tests_failed++; $display("FAIL zero_stream: got %h expected %h", st, EXP_ZERO); end
    endtask

    task automatic test_bad_digit();
        int base, nb;
        logic [127:0] st;
        bit ok;
        base = log_n;
        start_record(32'h0007_0A05, 1'b0);
        wait_end(ok);
        repeat (3) tick();
        collect(base, nb, st);
        tests_run += 3;
        if (st !== EXP_BAD)      begin tests_failed++; $display("FAIL bad_stream: got %h expected %h", st, EXP_BAD); end
        if (bad_at_end !== 1'b1) begin tests_failed++; $display("FAIL bad_at_end: got %b expected 1", bad_at_end); end
        if (bad_digit !== 1'b1)  begin tests_failed++; $display("FAIL bad_sticky: got %b expected 1", bad_digit); end
        base = log_n;
        start_record(32'h0450_9876, 1'b1);
        tests_run++;
        if (bad_digit !== 1'b0)  begin tests_failed++; $display("FAIL bad_clear: got %b expected 0", bad_digit); end
        wait_end(ok);
        repeat (3) tick();
        collect(base, nb, st);
        tests_run += 2;
        if (st !== EXP_VALID)    begin tests_failed++; $display("FAIL valid_stream: got %h expected %h", st, EXP_VALID); end
        if (bad_at_end !== 1'b0) begin tests_failed++; $display("FAIL valid_bad_at_end: got %b expected 0", bad_at_end); end
    endtask

    task automatic test_restart_ignored();
        int base, e0, nb, n0;
        logic [127:0] st;
        bit ok;
        base = log_n;
        e0   = end_n;
        start_record(32'h6000_0123, 1'b0);
        wait_bytes(base, 3, ok);
        data_in    = 32'h9999_9999;
        blank_lz   = 1'b1;
        start_send = 1'b1;
        tick();
        start_send = 1'b0;
        wait_end(ok);
        start_send = 1'b1;
        tick();
        start_send = 1'b0;
        n0 = log_n;
        repeat (40) tick();
        collect(base, nb, st);
        tests_run += 5;
        if (st !== EXP_BASIC) begin tests_failed++; $display("FAIL restart_stream: got %h expected %h", st, EXP_BASIC); end
        if (nb !== 11)        begin tests_failed++; $display("FAIL restart_count: got %0d expected 11", nb); end
        if (end_n - e0 !== 1) begin tests_failed++; $display("FAIL restart_end_count: got %0d expected 1", end_n - e0); end
        if (log_n !== n0)     begin tests_failed++; $display("FAIL done_start_bytes: got %0d expected %0d", log_n, n0); end
        if (busy !== 1'b0)    begin tests_failed++; $display("FAIL done_start_busy: got %b expected 0", busy); end
    endtask

    task automatic test_stall();
        int base, nb, n0, changed;
        logic [127:0] st;
        logic [7:0] d0;
        bit ok;
        base = log_n;
        start_record(32'h6000_0123, 1'b0);
        wait_bytes(base, 3, ok);
        hold_low = 1'b1;
        d0       = data_out;
        n0       = log_n;
        changed  = 0;
        for (int i = 0; i < 500; i++) begin
            tick();
            if (data_out !== d0) changed++;
        end
        tests_run += 4;
        if (log_n !== n0)  begin tests_failed++; $display("FAIL stall_no_tx: got %0d expected %0d", log_n, n0); end
        if (changed !== 0) begin tests_failed++; $display("FAIL stall_data_stable: got %0d changes expected 0", changed); end
        if (d0 !== 8'h32)  begin tests_failed++; $display("FAIL stall_held_byte: got %h expected 32", d0); end
        if (busy !== 1'b1) begin tests_failed++; $display("FAIL stall_busy: got %b expected 1", busy); end
        hold_low = 1'b0;
        wait_end(ok);
        repeat (3) tick();
        collect(base, nb, st);
        tests_run += 2;
        if (nb !== 11)        begin tests_failed++; $display("FAIL stall_count: got %0d expected 11", nb); end
        if (st !== EXP_BASIC) begin tests_failed++; $display("FAIL stall_stream: got %h expected %h", st, EXP_BASIC); end
    endtask

    task automatic test_reset_mid();
        int base, e0, nb;
        logic [127:0] st;
        bit ok;
        base = log_n;
        e0   = end_n;
        start_record(32'h6000_0123, 1'b0);
        wait_bytes(base, 5, ok);
        sys_rst_n = 1'b0;
        #1;
        tests_run += 5;
        if (tx_en !== 1'b0)     begin tests_failed++; $display("FAIL mid_tx_en: got %b expected 0", tx_en); end
        if (data_out !== 8'h00) begin tests_failed++; $display("FAIL mid_data_out: got %h expected 00", data_out); end
        if (busy !== 1'b0)      begin tests_failed++; $display("FAIL mid_busy: got %b expected 0", busy); end
        if (end_send !== 1'b0)  begin tests_failed++; $display("FAIL mid_end_send: got %b expected 0", end_send); end
        if (bad_digit !== 1'b0) begin tests_failed++; $display("FAIL mid_bad_digit: got %b expected 0", bad_digit); end
        repeat (10) tick();
        sys_rst_n = 1'b1;
        repeat (20) tick();
        tests_run++;
        if (end_n !== e0) begin tests_failed++; $display("FAIL mid_no_end: got %0d expected %0d", end_n, e0); end
        base = log_n;
        start_record(32'h6000_0123, 1'b0);
        wait_end(ok);
        repeat (3) tick();
        collect(base, nb, st);
        tests_run += 2;
        if (nb !== 11)        begin tests_failed++; $display("FAIL mid_restart_count: got %0d expected 11", nb); end
        if (st !== EXP_BASIC) begin tests_failed++; $display("FAIL mid_restart_stream: got %h expected %h", st, EXP_BASIC); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_blanking();
        test_bad_digit();
        test_restart_ignored();
        test_stall();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
